// File: rtl/serial_chunk_adder_if.sv
// Handshake and operand bus for serial_chunk_adder: the requester drives
// start/operands, the adder returns busy/done and the registered result.
interface serial_chunk_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, CHUNK bits per clock, LSB chunk first.
// Define SERIAL_CHUNK_ADDER_SUB_EN to enable subtract mode (a + ~b + cin).
module serial_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                clk,
   input logic                rst,
   serial_chunk_adder_if.slave bus
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   logic [WIDTH-1:0] b_eff;
   logic [CHUNK-1:0] a_k;
   logic [CHUNK-1:0] b_k;
   logic [CHUNK:0]   chunk_sum;
   logic             msb_cin;
   logic             last;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
   // b is inverted once at acceptance so the chunk datapath stays a plain adder.
   assign b_eff = bus.sub ? ~bus.b : bus.b;
`else
   logic unused_sub;
   assign unused_sub = bus.sub;
   assign b_eff      = bus.b;
`endif

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      a_k       = a_r[int'(idx)*CHUNK +: CHUNK];
      b_k       = b_r[int'(idx)*CHUNK +: CHUNK];
      chunk_sum = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry};
      // Carry into the chunk's top bit, recovered from its sum bit.
      msb_cin   = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ chunk_sum[CHUNK-1];
      last      = (idx == IW'(NCH - 1));
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_r   <= bus.a;
                  b_r   <= b_eff;
                  carry <= bus.cin;
                  sum_r <= '0;
                  idx   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sum_r[int'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
               carry <= chunk_sum[CHUNK];
               if (last) begin
                  cout_r <= chunk_sum[CHUNK];
                  ovf_r  <= msb_cin ^ chunk_sum[CHUNK];
                  state  <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state == S_RUN);
   assign bus.done = (state == S_DONE);
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: CHUNK=4 and CHUNK=16 instances, WIDTH=16.
// Subtract vectors switch with SERIAL_CHUNK_ADDER_SUB_EN.
module tb_serial_chunk_adder;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   serial_chunk_adder_if #(.WIDTH(16)) if4  ();
   serial_chunk_adder_if #(.WIDTH(16)) if16 ();

   serial_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
   serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic set_in(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
      if (sel == 0) begin
         if4.start = st; if4.a = a; if4.b = b; if4.cin = cin; if4.sub = sub;
      end else begin
         if16.start = st; if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
      end
   endtask

   function automatic logic get_done(input int sel);
      return (sel == 0) ? if4.done : if16.done;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? if4.busy : if16.busy;
   endfunction

   function automatic logic [17:0] get_res(input int sel);
      return (sel == 0) ? {if4.ovf, if4.cout, if4.sum} : {if16.ovf, if16.cout, if16.sum};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for done; reports edges waited and cycles busy was seen high.
   task automatic wait_done(input int sel, output bit found, output int lat, output int busy_cnt);
      found = 0; lat = 0; busy_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         if (get_done(sel)) begin
            found = 1;
            break;
         end
         if (get_busy(sel)) busy_cnt++;
         tick();
         lat++;
      end
   endtask

   task automatic run_vec(input int sel, input vec_t v, input int nch);
      bit          found;
      int          lat, busy_cnt;
      logic [17:0] res;
      set_in(sel, 1'b1, v.a, v.b, v.cin, v.sub);
      tick();
      // Operands are don't-care after acceptance; drive garbage to prove capture.
      set_in(sel, 1'b0, ~v.a, v.b ^ 16'h5A5A, ~v.cin, ~v.sub);
      wait_done(sel, found, lat, busy_cnt);
      check({v.name, " done_seen"}, 32'(found), 32'd1);
      check({v.name, " latency"},   32'(lat), 32'(nch));
      check({v.name, " busy_cycles"}, 32'(busy_cnt), 32'(nch));
      res = get_res(sel);
      check({v.name, " sum"},  32'(res[15:0]), 32'(v.exp_sum));
      check({v.name, " cout"}, 32'(res[16]),   32'(v.exp_cout));
      check({v.name, " ovf"},  32'(res[17]),   32'(v.exp_ovf));
      tick();
      check({v.name, " done_pulse_width"}, 32'(get_done(sel)), 32'd0);
      check({v.name, " result_held"}, 32'(get_res(sel)), 32'(res));
   endtask

   vec_t vecs[$];
   vec_t v;
   bit   found;
   int   lat, busy_cnt;
   bit   saw_done;

   initial begin
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple"});
      vecs.push_back('{16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1, "pos_ovf"});
      vecs.push_back('{16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0, "mixed"});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf"});
      vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "cin_only"});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "all_ones"});
      vecs.push_back('{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, "abcd"});
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"});
      vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"});
`else
      vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0, "sub_ignored"});
      vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0, "sub_ignored2"});
`endif

      // Reset: two cycles, released with start low.
      rst = 1'b1;
      set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      set_in(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("reset busy", 32'(if4.busy), 32'd0);
      check("reset done", 32'(if4.done), 32'd0);
      check("reset outputs", 32'({if4.ovf, if4.cout, if4.sum}), 32'd0);

      foreach (vecs[i]) run_vec(0, vecs[i], 4);

      // CHUNK = WIDTH: single RUN edge, identical ripple result.
      run_vec(1, vecs[0], 1);

      // Start re-asserted during RUN is ignored.
      set_in(0, 1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b0);
      tick();
      set_in(0, 1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0);
      tick();
      tick();
      set_in(0, 1'b0, 16'h1111, 16'h1111, 1'b0, 1'b0);
      wait_done(0, found, lat, busy_cnt);
      check("ignored_start done_seen", 32'(found), 32'd1);
      check("ignored_start sum", 32'(if4.sum), 32'h2143);
      check("ignored_start cout", 32'(if4.cout), 32'd0);
      tick();
      tick();
      check("ignored_start no_requeue", 32'(if4.busy), 32'd0);
      check("ignored_start sum_held", 32'(if4.sum), 32'h2143);

      // Reset on the 2nd RUN edge aborts the operation with no done pulse.
      set_in(0, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
      tick();
      set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", 32'(if4.busy), 32'd0);
      check("abort outputs", 32'({if4.done, if4.ovf, if4.cout, if4.sum}), 32'd0);
      saw_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (if4.done || if4.busy) saw_done = 1;
         tick();
      end
      check("abort no_done", 32'(saw_done), 32'd0);
      v = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "after_abort"};
      run_vec(0, v, 4);

      // Reset and start on the same edge: reset wins.
      rst = 1'b1;
      set_in(0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      check("rst_vs_start busy", 32'(if4.busy), 32'd0);
      tick();
      check("rst_vs_start still_idle", 32'(if4.busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
